// File: rtl/gpu_bus_pkg.sv
// Shared definitions for the CPU-to-GPU Wishbone write path: bus widths,
// GPU region map, request layout and write-master FSM encoding.
package gpu_bus_pkg;

  localparam int WB_ADDR_W = 27;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  localparam logic [WB_ADDR_W-1:0] REGION_CR_BASE      = 27'h000_0000;
  localparam logic [WB_ADDR_W-1:0] REGION_SPIRIT_BASE  = 27'h000_0100;
  localparam logic [WB_ADDR_W-1:0] REGION_SPIRIT_LAST  = 27'h000_0FFF;
  localparam logic [WB_ADDR_W-1:0] REGION_TILEMAP_BASE = 27'h000_1000;
  localparam logic [WB_ADDR_W-1:0] REGION_TEXTURE_BASE = 27'h000_2000;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic [WB_SEL_W-1:0]  sel;
  } wb_req_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } wb_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gpu_wb_req_fifo.sv
// Request buffer for the Wishbone write master. Ready is registered from the
// next occupancy, so it never allows a push into a full buffer.
module gpu_wb_req_fifo
  import gpu_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  wb_req_t                i_data,
  input  logic                   i_pop,
  output wb_req_t                o_head,
  output logic                   o_ready,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ready;
  logic [AW:0]   w_count_nxt;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push & r_ready;
  assign w_pop  = i_pop & (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_ready = r_ready;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/gpu_wb_write_master.sv
// Buffers CPU stores and issues them as single-beat Wishbone writes to the GPU
// slave port, holding stb for the slave's write phase and aborting on timeout.
module gpu_wb_write_master
  import gpu_bus_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int MIN_STB_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [WB_ADDR_W-1:0] i_req_addr,
  input  logic [WB_DATA_W-1:0] i_req_data,
  input  logic [WB_SEL_W-1:0]  i_req_sel,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [WB_ADDR_W-1:0] wb_adr_o,
  output logic [WB_DATA_W-1:0] wb_dat_o,
  output logic [WB_SEL_W-1:0]  wb_sel_o,
  input  logic                 wb_ack_i,
  output logic                 o_busy,
  output logic                 o_timeout,
  output logic [7:0]           o_timeout_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] MIN_HOLD     = 8'(MIN_STB_CYCLES);
  localparam logic [7:0] TIMEOUT_HOLD = 8'(TIMEOUT_CYCLES);

  wb_state_e            r_state;
  wb_state_e            w_state_nxt;
  logic [7:0]           r_hold_cnt;
  logic [WB_ADDR_W-1:0] r_adr;
  logic [WB_DATA_W-1:0] r_dat;
  logic [WB_SEL_W-1:0]  r_sel;
  logic                 r_timeout;
  logic [7:0]           r_timeout_cnt;

  wb_req_t              w_req;
  wb_req_t              w_head;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic                 w_pop;
  logic                 w_abort;

  assign w_req = {i_req_addr, i_req_data, i_req_sel};

  gpu_wb_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (i_req_valid),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_ready (o_req_ready),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Acks before MIN_HOLD are ignored: the slave acks ahead of its write strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (wb_ack_i && (r_hold_cnt >= MIN_HOLD)) begin
          w_state_nxt = ST_GAP;
        end else if (r_hold_cnt == TIMEOUT_HOLD) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_adr         <= '0;
      r_dat         <= '0;
      r_sel         <= '0;
      r_hold_cnt    <= '0;
      r_timeout     <= 1'b0;
      r_timeout_cnt <= '0;
    end else begin
      r_timeout <= w_abort;
      if (w_abort) r_timeout_cnt <= sat_inc8(r_timeout_cnt);
      if (w_pop) begin
        r_adr      <= w_head.addr;
        r_dat      <= w_head.data;
        r_sel      <= w_head.sel;
        r_hold_cnt <= 8'd1;
      end else if (r_state == ST_ACTIVE && w_state_nxt == ST_ACTIVE) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end
    end
  end

  assign wb_cyc_o      = (r_state == ST_ACTIVE);
  assign wb_stb_o      = (r_state == ST_ACTIVE);
  assign wb_we_o       = (r_state == ST_ACTIVE);
  assign wb_adr_o      = r_adr;
  assign wb_dat_o      = r_dat;
  assign wb_sel_o      = r_sel;
  assign o_busy        = (w_count != '0) | (r_state != ST_IDLE);
  assign o_timeout     = r_timeout;
  assign o_timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_gpu_wb_write_master.sv
// Randomized bench for gpu_wb_write_master with a phase-toggling slave model
// and an in-order request scoreboard.
module tb_gpu_wb_write_master;

  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [26:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } req_t;

  typedef struct {
    logic [26:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          len;
    int          wr;
    bit          ph0;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [26:0] i_req_addr = '0;
  logic [31:0] i_req_data = '0;
  logic [3:0]  i_req_sel = '0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [26:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic        o_busy, o_timeout;
  logic [7:0]  o_timeout_cnt;

  logic phase;
  int   ack_mode = 0;   // 0: ~phase & we, 1: ack = we, 2: ack low

  int   n_checks = 0;
  int   n_pass = 0;
  int   tout_model = 0;
  int   tpulses = 0;
  int   tlong = 0;
  int   unstable = 0;

  req_t to_send[$];
  req_t exp_q[$];
  txn_t obs[$];

  gpu_wb_write_master #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .MIN_STB_CYCLES (2),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_addr    (i_req_addr),
    .i_req_data    (i_req_data),
    .i_req_sel     (i_req_sel),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_adr_o      (wb_adr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_sel_o      (wb_sel_o),
    .wb_ack_i      (wb_ack_i),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout),
    .o_timeout_cnt (o_timeout_cnt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) phase <= reset_n ? ~phase : 1'b0;

  assign wb_ack_i = (ack_mode == 0) ? (~phase & wb_we_o) :
                    (ack_mode == 1) ? wb_we_o : 1'b0;

  // Bus monitor: one record per stb pulse.
  initial begin
    txn_t cur;
    int   run;
    bit   prev_tout;
    run = 0;
    prev_tout = 1'b0;
    cur = '{a: '0, d: '0, s: '0, len: 0, wr: 0, ph0: 1'b0};
    forever begin
      @(negedge clk);
      if (o_timeout === 1'b1) begin
        tpulses++;
        if (prev_tout) tlong++;
      end
      prev_tout = (o_timeout === 1'b1);
      if (wb_stb_o === 1'b1) begin
        if (run == 0) begin
          cur.a = wb_adr_o; cur.d = wb_dat_o; cur.s = wb_sel_o;
          cur.wr = 0; cur.ph0 = (phase == 1'b0);
        end else if ({wb_adr_o, wb_dat_o, wb_sel_o} !== {cur.a, cur.d, cur.s}) begin
          unstable++;
        end
        if (phase && wb_we_o) cur.wr++;
        run++;
      end else if (run != 0) begin
        cur.len = run;
        obs.push_back(cur);
        run = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_pending(input int prob, input int max_cyc,
                               output int stall_at, output bit ok);
    bit rdy;
    int acc;
    stall_at = -1; acc = 0; rdy = 1'b0; ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (i_req_valid && rdy) begin
        exp_q.push_back(to_send.pop_front());
        acc++;
        i_req_valid = 1'b0;
      end
      rdy = o_req_ready;
      if (!i_req_valid && to_send.size() > 0 && int'($urandom_range(99)) < prob) begin
        i_req_valid = 1'b1;
        i_req_addr = to_send[0].a; i_req_data = to_send[0].d; i_req_sel = to_send[0].s;
      end
      if (i_req_valid && !rdy && stall_at < 0) stall_at = acc;
      if (to_send.size() == 0 && !i_req_valid) begin
        ok = 1'b1;
        break;
      end
    end
    i_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (o_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000)
      $display("FAIL reset_cyc_stb_we: got %b want 000", {wb_cyc_o, wb_stb_o, wb_we_o}); else n_pass++;
    n_checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 63'd0)
      $display("FAIL reset_adr_dat_sel: got %h want 0", {wb_adr_o, wb_dat_o, wb_sel_o}); else n_pass++;
    n_checks++; if ({o_req_ready, o_busy, o_timeout} !== 3'b000)
      $display("FAIL reset_ready_busy_tout: got %b want 000", {o_req_ready, o_busy, o_timeout}); else n_pass++;
    n_checks++; if (o_timeout_cnt !== 8'd0)
      $display("FAIL reset_tcnt: got %0d want 0", o_timeout_cnt); else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (o_req_ready !== 1'b1)
      $display("FAIL reset_release_ready: got %b want 1", o_req_ready); else n_pass++;
  endtask

  task automatic test_single_cr;
    bit ok; int st;
    ack_mode = 0; obs.delete(); exp_q.delete();
    to_send.push_back('{a: 27'h000_0004, d: 32'h0000_001F, s: 4'hF});
    drive_pending(100, 20, st, ok);
    wait_idle(50, ok);
    n_checks++; if (!ok) $display("FAIL single_idle: busy=%b want 0", o_busy); else n_pass++;
    n_checks++; if (obs.size() != 1)
      $display("FAIL single_count: got %0d want 1", obs.size()); else n_pass++;
    if (obs.size() >= 1) begin
      n_checks++; if ({obs[0].a, obs[0].d, obs[0].s} !== {27'h4, 32'h1F, 4'hF})
        $display("FAIL single_fields: got %h/%h/%h want 0000004/0000001f/f", obs[0].a, obs[0].d, obs[0].s); else n_pass++;
      n_checks++; if (obs[0].len != (obs[0].ph0 ? 3 : 2))
        $display("FAIL single_len: got %0d want %0d", obs[0].len, obs[0].ph0 ? 3 : 2); else n_pass++;
      n_checks++; if (obs[0].wr != 1)
        $display("FAIL single_writes: got %0d want 1", obs[0].wr); else n_pass++;
    end
    n_checks++; if (tpulses != 0) $display("FAIL single_tout: got %0d want 0", tpulses); else n_pass++;
  endtask

  task automatic test_burst;
    bit ok; int st;
    ack_mode = 0; obs.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++)
      to_send.push_back('{a: 27'h000_2000 + 27'(4 * i), d: $urandom, s: 4'($urandom_range(1, 15))});
    drive_pending(100, 100, st, ok);
    n_checks++; if (!ok) $display("FAIL burst_drive: got incomplete want all accepted"); else n_pass++;
    n_checks++; if (st != FIFO_DEPTH + 1)
      $display("FAIL burst_stall_point: got %0d want %0d", st, FIFO_DEPTH + 1); else n_pass++;
    wait_idle(200, ok);
    n_checks++; if (!ok) $display("FAIL burst_idle: busy=%b want 0", o_busy); else n_pass++;
    n_checks++; if (obs.size() != 6)
      $display("FAIL burst_count: got %0d want 6", obs.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_checks++; if ({obs[i].a, obs[i].d, obs[i].s} !== {exp_q[i].a, exp_q[i].d, exp_q[i].s})
        $display("FAIL burst_fields[%0d]: got %h/%h/%h want %h/%h/%h", i, obs[i].a, obs[i].d, obs[i].s,
                 exp_q[i].a, exp_q[i].d, exp_q[i].s); else n_pass++;
      n_checks++; if (obs[i].wr != 1 || obs[i].len != (obs[i].ph0 ? 3 : 2))
        $display("FAIL burst_shape[%0d]: got len %0d writes %0d want len %0d writes 1", i, obs[i].len,
                 obs[i].wr, obs[i].ph0 ? 3 : 2); else n_pass++;
    end
  endtask

  task automatic test_ack_high;
    bit ok; int st;
    ack_mode = 1; obs.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++)
      to_send.push_back('{a: 27'($urandom), d: $urandom, s: 4'($urandom)});
    drive_pending(100, 50, st, ok);
    wait_idle(100, ok);
    n_checks++; if (obs.size() != 3)
      $display("FAIL ackhi_count: got %0d want 3", obs.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_checks++; if (obs[i].len != 2)
        $display("FAIL ackhi_len[%0d]: got %0d want 2", i, obs[i].len); else n_pass++;
      n_checks++; if ({obs[i].a, obs[i].d, obs[i].s} !== {exp_q[i].a, exp_q[i].d, exp_q[i].s})
        $display("FAIL ackhi_fields[%0d]: got %h/%h/%h want %h/%h/%h", i, obs[i].a, obs[i].d, obs[i].s,
                 exp_q[i].a, exp_q[i].d, exp_q[i].s); else n_pass++;
    end
  endtask

  task automatic test_timeout;
    bit ok, seen; int st, tp0;
    ack_mode = 2; obs.delete(); exp_q.delete();
    tp0 = tpulses; seen = 1'b0; ok = 1'b0;
    for (int i = 0; i < 2; i++)
      to_send.push_back('{a: 27'h000_0100 + 27'($urandom_range(0, 255)), d: $urandom, s: 4'hF});
    drive_pending(100, 50, st, ok);
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (o_timeout === 1'b1 && !seen) begin
        seen = 1'b1;
        tout_model++;
        ack_mode = 1;
      end
      if (seen && o_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!seen || !ok) $display("FAIL tout_seen: got seen=%0b idle=%0b want 1/1", seen, ok); else n_pass++;
    n_checks++; if (o_timeout_cnt !== 8'(tout_model))
      $display("FAIL tout_cnt: got %0d want %0d", o_timeout_cnt, tout_model); else n_pass++;
    n_checks++; if (tpulses - tp0 != 1 || tlong != 0)
      $display("FAIL tout_pulse: got %0d pulses (%0d long) want 1 (0 long)", tpulses - tp0, tlong); else n_pass++;
    n_checks++; if (obs.size() != 2) $display("FAIL tout_count: got %0d want 2", obs.size()); else n_pass++;
    if (obs.size() == 2 && exp_q.size() == 2) begin
      n_checks++; if (obs[0].len != 255) $display("FAIL tout_len: got %0d want 255", obs[0].len); else n_pass++;
      n_checks++; if (obs[1].len != 2) $display("FAIL tout_next_len: got %0d want 2", obs[1].len); else n_pass++;
      n_checks++; if ({obs[1].a, obs[1].d} !== {exp_q[1].a, exp_q[1].d})
        $display("FAIL tout_next_fields: got %h/%h want %h/%h", obs[1].a, obs[1].d, exp_q[1].a, exp_q[1].d); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    bit ok; int st, tp0;
    ack_mode = 2; obs.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++)
      to_send.push_back('{a: 27'h000_1000 + 27'(i), d: $urandom, s: 4'($urandom)});
    drive_pending(100, 50, st, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (wb_stb_o !== 1'b1) $display("FAIL rmid_active: stb got %b want 1", wb_stb_o); else n_pass++;
    tp0 = tpulses;
    reset_n = 1'b0;
    @(negedge clk);
    tout_model = 0;
    n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, o_req_ready, o_busy, o_timeout} !== 6'd0)
      $display("FAIL rmid_ctrl: got %b want 000000",
               {wb_cyc_o, wb_stb_o, wb_we_o, o_req_ready, o_busy, o_timeout}); else n_pass++;
    n_checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o, o_timeout_cnt} !== 71'd0)
      $display("FAIL rmid_data: got %h want 0", {wb_adr_o, wb_dat_o, wb_sel_o, o_timeout_cnt}); else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (o_req_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", o_req_ready); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if ({o_busy, wb_stb_o} !== 2'b00)
      $display("FAIL rmid_flushed: busy/stb got %b want 00", {o_busy, wb_stb_o}); else n_pass++;
    n_checks++; if (tpulses != tp0) $display("FAIL rmid_tout: got %0d pulses want 0", tpulses - tp0); else n_pass++;
    ack_mode = 1; obs.delete(); exp_q.delete();
    to_send.push_back('{a: 27'h000_0008, d: $urandom, s: 4'h3});
    drive_pending(100, 20, st, ok);
    wait_idle(50, ok);
    n_checks++; if (obs.size() != 1 || exp_q.size() != 1)
      $display("FAIL rmid_after_count: got %0d want 1", obs.size());
    else if ({obs[0].a, obs[0].d, obs[0].s} !== {exp_q[0].a, exp_q[0].d, exp_q[0].s})
      $display("FAIL rmid_after_fields: got %h/%h want %h/%h", obs[0].a, obs[0].d, exp_q[0].a, exp_q[0].d);
    else n_pass++;
  endtask

  task automatic test_occupancy;
    bit rdy, pushed, rose, prev_stb, done, saw_full;
    int occ;
    ack_mode = 1; obs.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++)
      to_send.push_back('{a: 27'($urandom), d: $urandom, s: 4'($urandom)});
    occ = 0; rdy = 1'b0; prev_stb = wb_stb_o; done = 1'b0; saw_full = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      pushed = i_req_valid && rdy;
      if (pushed) begin
        exp_q.push_back(to_send.pop_front());
        i_req_valid = 1'b0;
      end
      rose = wb_stb_o && !prev_stb;
      prev_stb = wb_stb_o;
      occ = occ + int'(pushed) - int'(rose);
      if (occ == FIFO_DEPTH) saw_full = 1'b1;
      n_checks++; if (o_req_ready !== (occ != FIFO_DEPTH))
        $display("FAIL occ_ready@%0d: got %b want %b (occupancy %0d)", c, o_req_ready, occ != FIFO_DEPTH, occ);
      else n_pass++;
      rdy = o_req_ready;
      if (!i_req_valid && to_send.size() > 0 && (c < 8 || $urandom_range(99) < 60)) begin
        i_req_valid = 1'b1;
        i_req_addr = to_send[0].a; i_req_data = to_send[0].d; i_req_sel = to_send[0].s;
      end
      if (to_send.size() == 0 && !i_req_valid && occ == 0 && o_busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    i_req_valid = 1'b0;
    n_checks++; if (!done) $display("FAIL occ_drain: got occupancy %0d want 0", occ); else n_pass++;
    n_checks++; if (!saw_full) $display("FAIL occ_full: got max below %0d want %0d", FIFO_DEPTH, FIFO_DEPTH); else n_pass++;
    n_checks++; if (obs.size() != 10) $display("FAIL occ_count: got %0d want 10", obs.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_checks++; if ({obs[i].a, obs[i].d, obs[i].s} !== {exp_q[i].a, exp_q[i].d, exp_q[i].s})
        $display("FAIL occ_fields[%0d]: got %h/%h/%h want %h/%h/%h", i, obs[i].a, obs[i].d, obs[i].s,
                 exp_q[i].a, exp_q[i].d, exp_q[i].s); else n_pass++;
    end
    n_checks++; if (unstable != 0) $display("FAIL bus_stable: got %0d changes want 0", unstable); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_cr();
    test_burst();
    test_ack_high();
    test_timeout();
    test_reset_mid();
    test_occupancy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
